// File: rtl/mydesign_mult_arbiter.sv
// Round-robin arbiter that time-shares one combinational multiplier between N_REQ requesters.
// Operand stage A feeds the multiplier; response stage R holds the tagged product.
module mydesign_mult_arbiter #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 6,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk_ci,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ*N_IN-1:0] req_a_i,
    input  logic [N_REQ*N_IN-1:0] req_b_i,
    output logic [N_IN-1:0]       mult_a_o,
    output logic [N_IN-1:0]       mult_b_o,
    input  logic [N_OUT-1:0]      mult_result_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [N_OUT-1:0]      rsp_result_o,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic                  busy_o,
    output logic [15:0]           op_count_o
);

    localparam int IDX_W = ID_W + 1;

    logic              a_valid_q, a_valid_d;
    logic [N_IN-1:0]   a_op_a_q, a_op_a_d;
    logic [N_IN-1:0]   a_op_b_q, a_op_b_d;
    logic [ID_W-1:0]   a_id_q, a_id_d;
    logic              r_valid_q, r_valid_d;
    logic [N_OUT-1:0]  r_result_q, r_result_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              r_accept_s;
    logic              a_adv_s;
    logic              a_accept_s;
    logic              found_s;
    logic              hs_s;
    logic [ID_W-1:0]   win_s;
    logic [IDX_W-1:0]  idx_s;
    logic [N_IN-1:0]   sel_a_s;
    logic [N_IN-1:0]   sel_b_s;
    logic [N_REQ-1:0]  ready_s;

    assign r_accept_s = ~r_valid_q | rsp_ready_i;
    assign a_adv_s    = a_valid_q & r_accept_s;
    assign a_accept_s = ~a_valid_q | a_adv_s;
    assign hs_s       = a_accept_s & found_s;

    // Round-robin search starting at rr_q, wrapping modulo N_REQ.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_s = {1'b0, rr_q} + IDX_W'(i);
            if (idx_s >= IDX_W'(N_REQ)) begin
                idx_s = idx_s - IDX_W'(N_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid_i[idx_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner operand mux and one-hot grant vector.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        ready_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s    = (win_s == ID_W'(i)) ? req_a_i[i*N_IN +: N_IN] : sel_a_s;
            sel_b_s    = (win_s == ID_W'(i)) ? req_b_i[i*N_IN +: N_IN] : sel_b_s;
            ready_s[i] = hs_s & (win_s == ID_W'(i));
        end
    end

    // Next-state for both pipeline stages, pointer and delivery counter.
    always_comb begin
        a_valid_d  = a_valid_q;
        a_op_a_d   = a_op_a_q;
        a_op_b_d   = a_op_b_q;
        a_id_d     = a_id_q;
        r_valid_d  = r_valid_q;
        r_result_d = r_result_q;
        r_id_d     = r_id_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;

        if (a_accept_s) begin
            a_valid_d = found_s;
        end else begin
            a_valid_d = a_valid_q;
        end

        if (hs_s) begin
            a_op_a_d = sel_a_s;
            a_op_b_d = sel_b_s;
            a_id_d   = win_s;
            rr_d     = (win_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : win_s + ID_W'(1);
        end else begin
            rr_d = rr_q;
        end

        if (r_accept_s) begin
            r_valid_d = a_valid_q;
        end else begin
            r_valid_d = r_valid_q;
        end

        if (a_adv_s) begin
            r_result_d = mult_result_i;
            r_id_d     = a_id_q;
        end else begin
            r_result_d = r_result_q;
        end

        if (r_valid_q && rsp_ready_i) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset drops every in-flight operation.
    always_ff @(posedge clk_ci or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q  <= 1'b0;
            a_op_a_q   <= '0;
            a_op_b_q   <= '0;
            a_id_q     <= '0;
            r_valid_q  <= 1'b0;
            r_result_q <= '0;
            r_id_q     <= '0;
            rr_q       <= '0;
            cnt_q      <= 16'd0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_op_a_q   <= a_op_a_d;
            a_op_b_q   <= a_op_b_d;
            a_id_q     <= a_id_d;
            r_valid_q  <= r_valid_d;
            r_result_q <= r_result_d;
            r_id_q     <= r_id_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ready_o  = ready_s;
    assign mult_a_o     = a_op_a_q;
    assign mult_b_o     = a_op_b_q;
    assign rsp_valid_o  = r_valid_q;
    assign rsp_result_o = r_result_q;
    assign rsp_id_o     = r_id_q;
    assign busy_o       = a_valid_q | r_valid_q;
    assign op_count_o   = cnt_q;

endmodule

// File: tb/tb_mydesign_mult_arbiter.sv
// Bench for mydesign_mult_arbiter: per-cycle check against an in-order queue model of the
// two-deep pipeline, plus directed scenarios with hand-computed expectations.
module tb_mydesign_mult_arbiter;

    localparam int N_IN  = 3;
    localparam int N_OUT = 6;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef struct { int a; int b; } pair_t;
    typedef struct { int a; int b; int id; int t; } op_t;

    logic                  clk_ci = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [N_REQ-1:0]      req_valid_i = '0;
    logic [N_REQ-1:0]      req_ready_o;
    logic [N_REQ*N_IN-1:0] req_a_i = '0;
    logic [N_REQ*N_IN-1:0] req_b_i = '0;
    logic [N_IN-1:0]       mult_a_o;
    logic [N_IN-1:0]       mult_b_o;
    logic [N_OUT-1:0]      mult_result_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i = 1'b1;
    logic [N_OUT-1:0]      rsp_result_o;
    logic [ID_W-1:0]       rsp_id_o;
    logic                  busy_o;
    logic [15:0]           op_count_o;

    int checks = 0;
    int errors = 0;

    pair_t rq[N_REQ][$];
    op_t   mq[$];
    int    m_rr  = 0;
    int    m_cnt = 0;
    int    cyc   = 0;

    int    m_n, m_w, m_idx, m_er;
    bit    m_vis, m_acc, m_found;
    op_t   m_op, m_aop;
    pair_t m_p;

    mydesign_mult_arbiter #(
        .N_IN (N_IN),
        .N_OUT(N_OUT),
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) dut (
        .clk_ci       (clk_ci),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .mult_a_o     (mult_a_o),
        .mult_b_o     (mult_b_o),
        .mult_result_i(mult_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_id_o     (rsp_id_o),
        .busy_o       (busy_o),
        .op_count_o   (op_count_o)
    );

    // Stand-in for the shared combinational multiplier.
    assign mult_result_i = N_OUT'(mult_a_o) * N_OUT'(mult_b_o);

    always #5 clk_ci = ~clk_ci;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input int a, input int b);
        pair_t p;
        p.a = a;
        p.b = b;
        rq[id].push_back(p);
    endtask

    // Requesters present the head of their own queue, holding it until granted.
    task automatic refresh();
        for (int i = 0; i < N_REQ; i++) begin
            if (rq[i].size() > 0) begin
                req_valid_i[i]            = 1'b1;
                req_a_i[i*N_IN +: N_IN]   = N_IN'(rq[i][0].a);
                req_b_i[i*N_IN +: N_IN]   = N_IN'(rq[i][0].b);
            end else begin
                req_valid_i[i]            = 1'b0;
                req_a_i[i*N_IN +: N_IN]   = '0;
                req_b_i[i*N_IN +: N_IN]   = '0;
            end
        end
    endtask

    function automatic bit idle();
        bit r = (mq.size() == 0);
        for (int i = 0; i < N_REQ; i++) r = r && (rq[i].size() == 0);
        return r;
    endfunction

    always @(posedge clk_ci) begin
        #1;
        refresh();
    end

    // Reference model: ops leave in acceptance order; an op is visible two cycles after
    // acceptance once at the head; at most two ops are in flight, and a full pipeline
    // accepts only when the consumer takes a response.
    always @(negedge clk_ci) begin
        if (rst_ni) begin
            m_n   = mq.size();
            m_vis = (m_n > 0) && ((cyc - mq[0].t) >= 2);
            m_acc = !(m_n == 2 && !rsp_ready_i);
            m_found = 1'b0;
            m_w     = 0;
            for (int k = 0; k < N_REQ; k++) begin
                m_idx = (m_rr + k) % N_REQ;
                if (!m_found && rq[m_idx].size() > 0) begin
                    m_found = 1'b1;
                    m_w     = m_idx;
                end
            end
            m_er = (m_acc && m_found) ? (1 << m_w) : 0;
            chk("req_ready", int'(req_ready_o), m_er);
            chk("rsp_valid", int'(rsp_valid_o), int'(m_vis));
            if (m_vis) begin
                chk("rsp_result", int'(rsp_result_o), (mq[0].a * mq[0].b) % 64);
                chk("rsp_id", int'(rsp_id_o), mq[0].id);
            end
            chk("busy", int'(busy_o), int'(m_n > 0));
            chk("op_count", int'(op_count_o), m_cnt);
            if (m_n == 2 || (m_n == 1 && !m_vis)) begin
                m_aop = mq[m_n-1];
                chk("mult_a", int'(mult_a_o), m_aop.a);
                chk("mult_b", int'(mult_b_o), m_aop.b);
            end
            if (m_vis && rsp_ready_i) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (m_acc && m_found) begin
                m_p     = rq[m_w].pop_front();
                m_op.a  = m_p.a;
                m_op.b  = m_p.b;
                m_op.id = m_w;
                m_op.t  = cyc;
                mq.push_back(m_op);
                m_rr = (m_w + 1) % N_REQ;
            end
        end
        cyc++;
    end

    task automatic do_reset();
        @(posedge clk_ci);
        #2;
        rst_ni = 1'b0;
        for (int i = 0; i < N_REQ; i++) rq[i].delete();
        mq.delete();
        m_rr  = 0;
        m_cnt = 0;
        refresh();
        #1;
        chk("rst_rsp_valid", int'(rsp_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_op_count", int'(op_count_o), 0);
        chk("rst_rsp_result", int'(rsp_result_o), 0);
        @(posedge clk_ci);
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while (!idle() && i < budget) begin
            @(negedge clk_ci);
            #1;
            i++;
        end
        chk("drain_idle", int'(idle()), 1);
    endtask

    int exp_res[8] = '{49, 6, 0, 42, 2, 16, 25, 3};

    initial begin
        // Reset values
        repeat (2) @(posedge clk_ci);
        #2;
        chk("init_rsp_valid", int'(rsp_valid_o), 0);
        chk("init_req_ready", int'(req_ready_o), 0);
        chk("init_rsp_id", int'(rsp_id_o), 0);
        chk("init_mult_a", int'(mult_a_o), 0);
        chk("init_mult_b", int'(mult_b_o), 0);
        chk("init_busy", int'(busy_o), 0);
        chk("init_op_count", int'(op_count_o), 0);
        rst_ni = 1'b1;

        // Single request from requester 2
        rsp_ready_i = 1'b1;
        push(2, 5, 7);
        refresh();
        @(negedge clk_ci);
        chk("single_ready", int'(req_ready_o), 4);
        repeat (2) @(negedge clk_ci);
        chk("single_valid", int'(rsp_valid_o), 1);
        chk("single_result", int'(rsp_result_o), 35);
        chk("single_id", int'(rsp_id_o), 2);
        @(negedge clk_ci);
        chk("single_count", int'(op_count_o), 1);

        // All requesters continuously valid
        do_reset();
        rsp_ready_i = 1'b1;
        push(0, 7, 7); push(0, 1, 2);
        push(1, 2, 3); push(1, 4, 4);
        push(2, 0, 6); push(2, 5, 5);
        push(3, 6, 7); push(3, 3, 1);
        refresh();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_ci);
            if (k < 8) chk("rr_grant", int'(req_ready_o), 1 << (k % 4));
            if (k >= 2) begin
                chk("rr_result", int'(rsp_result_o), exp_res[k-2]);
                chk("rr_id", int'(rsp_id_o), (k - 2) % 4);
            end
        end
        drain(20);

        // Backpressure
        do_reset();
        rsp_ready_i = 1'b0;
        push(1, 2, 3); push(1, 3, 3); push(1, 4, 5); push(1, 7, 1);
        refresh();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_ci);
            chk("bp_ready", int'(req_ready_o), (k < 2) ? 2 : 0);
            if (k >= 2) begin
                chk("bp_hold_valid", int'(rsp_valid_o), 1);
                chk("bp_hold_result", int'(rsp_result_o), 6);
            end
        end
        @(posedge clk_ci);
        #2;
        rsp_ready_i = 1'b1;
        drain(20);
        @(negedge clk_ci);
        chk("bp_count", int'(op_count_o), 4);

        // Fairness: requester 3 rises when the pointer is at 1
        do_reset();
        rsp_ready_i = 1'b1;
        push(0, 1, 1); push(0, 2, 2); push(0, 3, 3); push(0, 4, 4);
        refresh();
        @(negedge clk_ci);
        chk("fair_first", int'(req_ready_o), 1);
        @(posedge clk_ci);
        #2;
        push(3, 6, 6);
        refresh();
        @(negedge clk_ci);
        chk("fair_req3", int'(req_ready_o), 8);
        @(negedge clk_ci);
        chk("fair_back0", int'(req_ready_o), 1);
        drain(20);

        // Reset with both stages full
        do_reset();
        rsp_ready_i = 1'b0;
        push(2, 1, 2); push(2, 3, 4); push(2, 5, 6);
        refresh();
        repeat (3) @(negedge clk_ci);
        chk("full_busy", int'(busy_o), 1);
        do_reset();
        rsp_ready_i = 1'b1;
        push(0, 6, 5); push(1, 1, 1);
        refresh();
        @(negedge clk_ci);
        chk("post_rst_grant0", int'(req_ready_o), 1);
        @(negedge clk_ci);
        chk("post_rst_grant1", int'(req_ready_o), 2);
        @(negedge clk_ci);
        chk("post_rst_valid", int'(rsp_valid_o), 1);
        chk("post_rst_result", int'(rsp_result_o), 30);
        chk("post_rst_id", int'(rsp_id_o), 0);
        drain(20);

        // Counter wrap
        do_reset();
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 65537; i++) push(0, i % 8, (i / 8) % 8);
        refresh();
        drain(70000);
        @(negedge clk_ci);
        chk("wrap_count", int'(op_count_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
